fft_stage_counter: RTL

- Parametrised radix-2 FFT sequencer.
- Steps through every stage and every butterfly of an N = 2^LOG2N point in-place FFT.
- For each butterfly, outputs the stage index, butterfly index, both operand addresses and the twiddle address.
- Sits between the FFT control FSM and the data/twiddle memories. Adds start/enable handshake, DIT/DIF mode and a sticky done flag to the fixed 3-bit stage counter.

---
 rtl/fft_pkg.sv | 9 +
 rtl/fft_bfly_addr_gen.sv | 35 +++
 rtl/fft_stage_counter.sv | 84 ++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: FSM state encoding, stage-index width helper and FFT size limits shared by the sequencer and memory blocks
package fft_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int LOG2N_MIN = 2;
  localparam int LOG2N_MAX = 12;
  function automatic int sw_of(input int log2n);
    return (log2n > 2) ? $clog2(log2n) : 1;
  endfunction
endpackage

// File: rtl/fft_bfly_addr_gen.sv
// fft_bfly_addr_gen: maps (stage, butterfly) to operand and twiddle addresses of an in-place radix-2 FFT
//   stage_i   : stage index 0..LOG2N-1
//   bfly_i    : butterfly index within the stage
//   addr_a_o  : upper-leg data address
//   addr_b_o  : lower-leg data address (addr_a_o + span)
//   tw_addr_o : twiddle ROM address
module fft_bfly_addr_gen import fft_pkg::*; #(
  parameter int LOG2N = 3,
  parameter bit DIF = 1'b0,
  localparam int SW = sw_of(LOG2N)
) (
  input  logic [SW-1:0]    stage_i,
  input  logic [LOG2N-2:0] bfly_i,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [LOG2N-2:0] tw_addr_o
);
  localparam logic [SW-1:0] SMAX = SW'(LOG2N - 1);
  logic [SW-1:0]    sh;
  logic [SW-1:0]    tsh;
  logic [LOG2N-1:0] span;
  logic [LOG2N-2:0] pos;
  logic [LOG2N-2:0] grp;
  always_comb begin
    sh = DIF ? SMAX - stage_i : stage_i;
    tsh = DIF ? stage_i : SMAX - stage_i;
    span = LOG2N'(1) << sh;
    pos = bfly_i & (LOG2N-1)'(span - LOG2N'(1));
    grp = bfly_i >> sh;
    // group base is grp*2*span; the span bit of addr_a is always zero, so addr_b never carries out
    addr_a_o = (LOG2N'(grp) << sh << 1) | LOG2N'(pos);
    addr_b_o = addr_a_o + span;
    tw_addr_o = pos << tsh;
  end
endmodule

// File: rtl/fft_stage_counter.sv
// fft_stage_counter: radix-2 FFT sequencer stepping through every stage and butterfly with start/enable handshake
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : begin a pass (honoured in IDLE or DONE)
//   en         : advance one butterfly this cycle
//   stage/bfly : current stage and butterfly index
//   addr_a/addr_b/tw_addr : operand and twiddle addresses, valid only while valid=1
//   valid/last/busy/done  : butterfly present, final butterfly, pass running, sticky completion
module fft_stage_counter import fft_pkg::*; #(
  parameter int LOG2N = 3,
  parameter bit DIF = 1'b0,
  localparam int NB = 1 << (LOG2N - 1),
  localparam int SW = sw_of(LOG2N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
  output logic [SW-1:0]    stage,
  output logic [LOG2N-2:0] bfly,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             valid,
  output logic             last,
  output logic             busy,
  output logic             done
);
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [LOG2N-2:0] B_LAST = (LOG2N-1)'(NB - 1);
  state_e           state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [LOG2N-2:0] bfly_q, bfly_d;
  logic             done_q, done_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      bfly_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q <= bfly_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d = bfly_q;
    done_d = done_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RUN;
        stage_d = '0;
        bfly_d = '0;
        done_d = 1'b0;
      end
      RUN: if (en) begin
        // NB is a power of two, so the increment wraps to 0 after the last butterfly
        bfly_d = bfly_q + 1'b1;
        if (bfly_q == B_LAST) begin
          stage_d = (stage_q == S_LAST) ? '0 : stage_q + 1'b1;
          state_d = (stage_q == S_LAST) ? DONE : RUN;
          done_d = (stage_q == S_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign stage = stage_q;
  assign bfly = bfly_q;
  assign valid = (state_q == RUN);
  assign busy = valid;
  assign last = valid & (stage_q == S_LAST) & (bfly_q == B_LAST);
  assign done = done_q;
  fft_bfly_addr_gen #(.LOG2N(LOG2N), .DIF(DIF)) u_addr_gen (
    .stage_i  (stage_q),
    .bfly_i   (bfly_q),
    .addr_a_o (addr_a),
    .addr_b_o (addr_b),
    .tw_addr_o(tw_addr)
  );
endmodule
